// File: rtl/spike_serializer.sv
// spike_serializer
// Captures one parallel hidden-layer spike vector per timestep and replays it
// to the output neuron as one (spike, address) pair per clock, lowest index first.
//
// Ports:
//   clk          rising-edge clock
//   resetn       asynchronous active-low reset
//   spikes_in    parallel spikes for one timestep (bit i = neuron i)
//   spikes_valid capture strobe for spikes_in
//   ovf_clr      synchronous clear of the sticky overrun flag
//   spike_out    registered spike pulse to the output neuron
//   addr_out     registered address of the emitted spike (0 when spike_out=0)
//   busy         high while a captured frame still has unemitted bits
//   frame_done   one-cycle pulse after the last spike of a frame
//   overrun      sticky: a frame was dropped
//
// Optional build macro SPIKE_SERIALIZER_SHADOW_BUF_EN adds a one-deep shadow
// frame buffer so a frame arriving mid-scan is queued instead of dropped.

module spike_serializer #(
  parameter int unsigned N_IN   = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [N_IN-1:0]   spikes_in,
  input  logic              spikes_valid,
  input  logic              ovf_clr,
  output logic              spike_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t              state_q, state_d;
  logic [N_IN-1:0]     pending_q, pending_d;
  logic [N_IN-1:0]     pending_clr;
  logic [ADDR_W-1:0]   low_idx;
  logic                spike_d, busy_d, done_d, ovf_d;
  logic [ADDR_W-1:0]   addr_d;
`ifdef SPIKE_SERIALIZER_SHADOW_BUF_EN
  logic [N_IN-1:0]     shadow_q, shadow_d;
  logic                shadow_vld_q, shadow_vld_d;
`endif

  // Lowest set bit of the pending vector, and the vector with that bit cleared
  always_comb begin
    low_idx = '0;
    for (int i = int'(N_IN) - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = ADDR_W'(i);
    end
  end

  assign pending_clr = pending_q & (pending_q - N_IN'(1));

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    spike_d   = 1'b0;
    addr_d    = '0;
    busy_d    = busy;
    done_d    = 1'b0;
    ovf_d     = overrun & ~ovf_clr;
`ifdef SPIKE_SERIALIZER_SHADOW_BUF_EN
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef SPIKE_SERIALIZER_SHADOW_BUF_EN
        // A frame queued while finishing the previous one starts first
        if (shadow_vld_q) begin
          pending_d    = shadow_q;
          busy_d       = 1'b1;
          state_d      = (|shadow_q) ? SCAN : DONE;
          shadow_vld_d = 1'b0;
          if (spikes_valid) begin
            shadow_d     = spikes_in;
            shadow_vld_d = 1'b1;
          end
        end else
`endif
        if (spikes_valid) begin
          pending_d = spikes_in;
          busy_d    = 1'b1;
          state_d   = (|spikes_in) ? SCAN : DONE;
        end
      end

      SCAN: begin
        spike_d   = 1'b1;
        addr_d    = low_idx;
        pending_d = pending_clr;
        if (pending_clr == '0) state_d = DONE;
      end

      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
`ifdef SPIKE_SERIALIZER_SHADOW_BUF_EN
        // Chain straight into the queued frame; busy never drops
        if (shadow_vld_q) begin
          pending_d    = shadow_q;
          busy_d       = 1'b1;
          state_d      = (|shadow_q) ? SCAN : DONE;
          shadow_vld_d = 1'b0;
        end
`endif
      end

      default: state_d = IDLE;
    endcase

    // Frame arriving while a frame is still in flight
    if (spikes_valid && (state_q != IDLE)) begin
`ifdef SPIKE_SERIALIZER_SHADOW_BUF_EN
      // In DONE the shadow is vacated on this edge, so it can always be refilled
      if (!shadow_vld_q || (state_q == DONE)) begin
        shadow_d     = spikes_in;
        shadow_vld_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
`else
      ovf_d = 1'b1;
`endif
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      spike_out  <= 1'b0;
      addr_out   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      spike_out  <= spike_d;
      addr_out   <= addr_d;
      busy       <= busy_d;
      frame_done <= done_d;
      overrun    <= ovf_d;
    end
  end

`ifdef SPIKE_SERIALIZER_SHADOW_BUF_EN
  // Shadow frame buffer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
    end
  end
`endif

endmodule
